// File: rtl/sum_accum_pkg.sv
// sum_accum_pkg -- shared definitions for the sum_accumulator block.
//
// Contents:
//   sum_acc_state_e     FSM states: IDLE, ACCUM, DONE
//   SUM_ACC_SIZE_DEF    default operand/sum width
//   SUM_ACC_COUNT_DEF   default number of operands per result
//   sum_acc_cnt_w()     counter width able to hold 0..count
package sum_accum_pkg;

    localparam int SUM_ACC_SIZE_DEF  = 4;
    localparam int SUM_ACC_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } sum_acc_state_e;

    // The operand counter runs 0..count, so it needs room for count itself.
    function automatic int sum_acc_cnt_w(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if -- operand/result handshake bundle for sum_accumulator.
//
// Parameter:
//   SIZE        operand and sum width
// Signals:
//   in_valid    producer offers in_data
//   in_ready    accumulator can take an operand this cycle
//   in_data     unsigned operand
//   out_valid   out_sum/out_ovf hold a completed result
//   out_ready   consumer takes the result this cycle
//   out_sum     accumulated sum
//   out_ovf     a carry-out occurred during the accumulation
// Modports:
//   master      the environment (operand producer and result consumer)
//   slave       the accumulator
interface sum_accumulator_if
    import sum_accum_pkg::*;
#(
    parameter int SIZE = SUM_ACC_SIZE_DEF
);

    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_sum;
    logic            out_ovf;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf
    );

endinterface

// File: rtl/sum_accumulator_rca.sv
// RCA_nocin -- N-bit ripple-carry adder without carry-in.
//
// Purely combinational.
// Ports:
//   x, y    N-bit unsigned addends
//   s       low N bits of x + y
//   cout    carry out of the top bit
module RCA_nocin #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator -- sums COUNT unsigned operands and presents one result.
//
// Operands arrive on a valid/ready handshake; after the COUNT-th accepted
// operand the sum is held in DONE until the consumer takes it. out_ovf is
// sticky across the accumulation and records any carry-out of the adder.
//
// Parameters:
//   SIZE     operand, sum and accumulator width (>= 2)
//   COUNT    operands per result (>= 1)
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   clr      synchronous clear; abandons the current accumulation
//   bus      sum_accumulator_if.slave (in_* operand side, out_* result side)
// Build option:
//   SUM_ACC_SATURATE_EN  when defined, an add with carry-out saturates acc
//                        to all-ones instead of wrapping.
module sum_accumulator
    import sum_accum_pkg::*;
#(
    parameter int SIZE  = SUM_ACC_SIZE_DEF,
    parameter int COUNT = SUM_ACC_COUNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    sum_accumulator_if.slave   bus
);

    localparam int             CW       = sum_acc_cnt_w(COUNT);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(COUNT - 1);

    sum_acc_state_e  state_q, state_d;
    logic [SIZE-1:0] acc_q,   acc_d;
    logic            ovf_q,   ovf_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic [SIZE-1:0] add_sum;
    logic            add_cout;
    logic [SIZE-1:0] add_res;

    logic            rdy;
    logic            accept;
    logic            consume;

    // ------------------------------------------------------------------
    // Datapath adder: acc + incoming operand, carry-out only feeds ovf.
    // ------------------------------------------------------------------
    RCA_nocin #(
        .N (SIZE)
    ) u_add (
        .x    (acc_q),
        .y    (bus.in_data),
        .s    (add_sum),
        .cout (add_cout)
    );

`ifdef SUM_ACC_SATURATE_EN
    // Once saturated, acc is all-ones and any nonzero operand carries out
    // again, so the value sticks at all-ones for the rest of the run.
    assign add_res = add_cout ? {SIZE{1'b1}} : add_sum;
`else
    assign add_res = add_sum;
`endif

    // ------------------------------------------------------------------
    // Handshake. clr blocks new operands but does not hide a held result,
    // so a consume may land on the same edge as a clear.
    // ------------------------------------------------------------------
    assign rdy     = (state_q != DONE) && !clr;
    assign accept  = bus.in_valid && rdy;
    assign consume = (state_q == DONE) && bus.out_ready;

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;

    // ------------------------------------------------------------------
    // Next-state / datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // First operand loads directly; no add, no carry.
                    acc_d   = bus.in_data;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_ONE;
                    state_d = (COUNT == 1) ? DONE : ACCUM;
                end
            end

            ACCUM: begin
                if (accept) begin
                    acc_d = add_res;
                    ovf_d = ovf_q | add_cout;
                    cnt_d = cnt_q + CNT_ONE;
                    // cnt_q already counts the accepts so far; this one is
                    // the COUNT-th when cnt_q sits at COUNT-1.
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // acc/ovf held so out_sum/out_ovf stay stable until taken.
                if (consume) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides any accept or consume on the same edge.
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator -- self-checking bench for sum_accumulator (SIZE=4, COUNT=4).
//
// A behavioural model tracks how many operands have been taken, their true
// (unbounded) total and whether a result is pending; expected outputs are
// derived from that total. Directed sequences pin known values, then a
// randomized phase runs against the model. Define SUM_ACC_SATURATE_EN for
// both DUT and bench to check the saturating build.
module tb_sum_accumulator;

    localparam int SIZE  = 4;
    localparam int COUNT = 4;
    localparam int MODV  = 1 << SIZE;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    int n_tests = 0;
    int n_fail  = 0;

    sum_accumulator_if #(.SIZE(SIZE)) bus ();

    sum_accumulator #(
        .SIZE  (SIZE),
        .COUNT (COUNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int m_total = 0;   // true sum of accepted operands
    int m_cnt   = 0;   // operands accepted in this accumulation
    bit m_done  = 1'b0;

    function automatic int exp_sum(input int total);
`ifdef SUM_ACC_SATURATE_EN
        return (total >= MODV) ? MODV - 1 : total;
`else
        return total % MODV;
`endif
    endfunction

    function automatic int exp_ovf(input int total);
        return (total >= MODV) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            m_total <= 0;
            m_cnt   <= 0;
            m_done  <= 1'b0;
        end else if (m_done) begin
            if (bus.out_ready) begin
                m_total <= 0;
                m_cnt   <= 0;
                m_done  <= 1'b0;
            end
        end else if (bus.in_valid) begin
            m_total <= m_total + int'(bus.in_data);
            m_cnt   <= m_cnt + 1;
            if (m_cnt + 1 == COUNT) m_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(!m_done && !clr));
        chk("out_valid", 32'(bus.out_valid), 32'(m_done));
        if (m_done) begin
            chk("out_sum", 32'(bus.out_sum), 32'(exp_sum(m_total)));
            chk("out_ovf", 32'(bus.out_ovf), 32'(exp_ovf(m_total)));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = SIZE'(v);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) break;
            step();
        end
        chk("take_wait_valid", 32'(bus.out_valid), 32'd1);
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_result(input string name, input int s, input int o);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_sum"}, 32'(bus.out_sum), 32'(s));
        chk({name, "_ovf"}, 32'(bus.out_ovf), 32'(o));
    endtask

    initial begin
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // 1,2,3,4 back-to-back; result appears right after the 4th accept
        send(1); send(2); send(3);
        chk("lat_no_valid_early", 32'(bus.out_valid), 32'd0);
        send(4);
        chk_result("seq1234", 10, 0);

        // Backpressure: held for 3 cycles, consumed on the 4th
        for (int i = 0; i < 3; i++) begin
            step();
            chk_result("hold", 10, 0);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        take();
        chk("after_take_valid", 32'(bus.out_valid), 32'd0);
        chk("after_take_ready", 32'(bus.in_ready), 32'd1);

        // Overflow build
        send(5); send(6); send(7); send(8);
`ifdef SUM_ACC_SATURATE_EN
        chk_result("seq5678", 15, 1);
`else
        chk_result("seq5678", 10, 1);
`endif
        take();

        // clr after two accepts abandons the partial sum
        send(9); send(9);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_sum", 32'(bus.out_sum), 32'd0);
        chk("clr_ovf", 32'(bus.out_ovf), 32'd0);
        send(1); send(1); send(1); send(1);
        chk_result("after_clr", 4, 0);
        take();

        // clr and in_valid together in ACCUM: operand dropped, acc cleared
        send(3);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = SIZE'(5);
        #1;
        chk("clr_blocks_ready", 32'(bus.in_ready), 32'd0);
        step();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_acc_zero", 32'(bus.out_sum), 32'd0);
        chk("clr_no_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-accumulation with gaps
        send(1); step(); send(2); step(); step(); send(3);
        rst = 1'b1;
        #1;
        chk("mid_rst_sum", 32'(bus.out_sum), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        step();
        rst = 1'b0;
        send(2); send(2); send(2); send(2);
        chk_result("after_rst", 8, 0);
        take();

        // Randomized phase, checked by the per-cycle compare
        for (int i = 0; i < 800; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_data   = SIZE'($urandom);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            clr           = ($urandom_range(0, 29) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clr           = 1'b0;
        rst           = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter SIZE, default 4: operand, sum and accumulator width in bits (SIZE >= 2).
REQ-002 Parameter COUNT, default 4: number of operands summed per result (COUNT >= 1).
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 clr  input  1: synchronous clear; abandons the current accumulation.
REQ-006 in_valid  input  1: the operand on in_data is offered.
REQ-007 in_ready  output  1: the block can accept an operand this cycle.
REQ-008 in_data  input  SIZE: unsigned operand.
REQ-009 out_valid  output  1: out_sum and out_ovf hold a completed result.
REQ-010 out_ready  input  1: the consumer takes the result this cycle.
REQ-011 out_sum  output  SIZE: accumulated sum.
REQ-012 out_ovf  output  1: sticky flag; a carry-out occurred during this accumulation.

Function
REQ-013 An operand is accepted on a rising edge only when in_valid and in_ready are both high.
REQ-014 A result is consumed on a rising edge only when out_valid and out_ready are both high.
REQ-015 FSM states are IDLE, ACCUM and DONE.
REQ-016 IDLE: in_ready = 1 and out_valid = 0.
- On accept: acc <= in_data, ovf <= 0, cnt <= 1.
- Next state is DONE if COUNT == 1, otherwise ACCUM.
REQ-017 ACCUM: in_ready = 1 and out_valid = 0.
- On accept: acc <= SIZE-bit sum of acc and in_data, ovf <= ovf | carry-out, cnt <= cnt + 1.
- The COUNT-th accept moves the FSM to DONE.
- With in_valid low, all state holds.
REQ-018 DONE: in_ready = 0 and out_valid = 1.
- out_sum and out_ovf are stable until consumed.
- On consume, the FSM moves to IDLE.
REQ-019 Latency: out_valid rises on the edge after the COUNT-th accept; a new operand can be accepted the cycle after the consume.
REQ-020 The adder has no carry-in; the sum is the low SIZE bits, and the carry-out feeds ovf only.
REQ-021 Arithmetic wraps modulo 2^SIZE unless SUM_ACC_SATURATE_EN is defined.
REQ-022 cnt width is $clog2(COUNT+1); cnt never exceeds COUNT.
REQ-023 clr high: the next state is IDLE with acc, ovf and cnt cleared, in every state, including DONE with the result unconsumed.
REQ-024 clr has priority over a simultaneous accept or consume.
- in_ready is forced to 0 while clr is high.
- out_valid is not masked by clr, so a consume may coincide with a clr in DONE.
REQ-025 out_sum and out_ovf show acc and ovf in every state; they are valid only while out_valid = 1.

Reset
REQ-026 rst asynchronously forces state IDLE, acc = 0, ovf = 0, cnt = 0.
- Outputs while rst is high: in_ready = 1, out_valid = 0, out_sum = 0, out_ovf = 0.
REQ-027 Reset asserted mid-accumulation discards the partial sum; operation restarts cleanly after release.

Configuration
REQ-028 Macro SUM_ACC_SATURATE_EN: when defined, an add with carry-out loads acc with all-ones, and acc stays all-ones for the rest of the accumulation; ovf is still set.
REQ-029 When SUM_ACC_SATURATE_EN is not defined, an add with carry-out loads the wrapped SIZE-bit sum and sets ovf.

Structure
REQ-030 Shared package sum_accum_pkg holds:
- the FSM state enum (IDLE, ACCUM, DONE);
- default constants SUM_ACC_SIZE_DEF = 4 and SUM_ACC_COUNT_DEF = 4.
REQ-031 Exactly one sub-module: the existing RCA_nocin ripple adder, instantiated SIZE-wide with x = acc and y = in_data; its cout drives the overflow logic.
REQ-032 All registers are in sum_accumulator; the adder instance is purely combinational.

Verification (SIZE=4, COUNT=4)
REQ-033 Operands 1, 2, 3, 4 back-to-back -> out_sum = 10, out_ovf = 0, out_valid rises the edge after the 4th accept.
REQ-034 Operands 5, 6, 7, 8 -> wrap build: out_sum = 10, out_ovf = 1; SUM_ACC_SATURATE_EN build: out_sum = 15, out_ovf = 1.
REQ-035 out_ready low for 3 cycles in DONE -> out_valid and out_sum held and in_ready = 0 throughout; the result is consumed on the 4th cycle.
REQ-036 clr after 2 accepts (values 9, 9), then operands 1, 1, 1, 1 -> out_sum = 4, out_ovf = 0.
REQ-037 rst asserted after 3 accepts with in_valid gaps -> all outputs return to reset values immediately; the next operands 2, 2, 2, 2 -> out_sum = 8.
REQ-038 clr and in_valid high on the same edge in ACCUM -> the operand is not accepted and the state is IDLE with acc = 0.
